// File: rtl/debug_trap_collect_pkg.sv
// -----------------------------------------------------------------------------
// debug_trap_collect_pkg
//   Shared debug definitions used by the data-breakpoint trap collector and the
//   DR7 enable decoder:
//     - NUM_BP          : number of hardware breakpoints
//     - DR7_* offsets   : position of the L/G enable bits for a breakpoint
//     - dtc_state_e     : trap-collector FSM encoding (IDLE / ACCUM / REQ)
// -----------------------------------------------------------------------------
package debug_trap_collect_pkg;

  localparam int NUM_BP = 4;

  // DR7 holds one {G,L} pair per breakpoint, breakpoint n at bits [2n+1:2n].
  localparam int DR7_BP_STRIDE = 2;
  localparam int DR7_L_OFS     = 0;
  localparam int DR7_G_OFS     = 1;

  typedef enum logic [1:0] {
    DTC_IDLE  = 2'd0,  // accumulator empty, no request
    DTC_ACCUM = 2'd1,  // hits collected for the in-flight instruction
    DTC_REQ   = 2'd2   // debug trap requested, waiting for exc_ack
  } dtc_state_e;

endpackage : debug_trap_collect_pkg

// File: rtl/debug_bp_enable_decode.sv
// -----------------------------------------------------------------------------
// debug_bp_enable_decode
//   Maps the breakpoint enable field of DR7 to one enable bit per breakpoint.
//   A breakpoint is enabled when either its local (L) or global (G) bit is set.
//   Shared between the data-breakpoint and instruction-breakpoint paths.
//
// Ports
//   dr7_lg_i : DR7 enable field, {G,L} pair per breakpoint
//   en_o     : per-breakpoint enable
// -----------------------------------------------------------------------------
module debug_bp_enable_decode
  import debug_trap_collect_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic [DR7_BP_STRIDE*NUM_BP-1:0] dr7_lg_i,
  output logic [NUM_BP-1:0]               en_o
);

  for (genvar n = 0; n < NUM_BP; n++) begin : g_en
    assign en_o[n] = dr7_lg_i[DR7_BP_STRIDE*n + DR7_L_OFS]
                   | dr7_lg_i[DR7_BP_STRIDE*n + DR7_G_OFS];
  end

endmodule : debug_bp_enable_decode

// File: rtl/debug_trap_collect.sv
// -----------------------------------------------------------------------------
// debug_trap_collect
//   Collects data-breakpoint hits for the in-flight instruction and, when that
//   instruction commits, reports them as a one-cycle DR6 update and raises a
//   debug-trap request if any reported breakpoint is enabled in DR7. Data
//   breakpoints are traps, so nothing is reported before commit.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   dr7             : debug control (L/G enable pairs in the low bits)
//   rd_debug_read   : read-side breakpoint hits, level-valid per cycle
//   wr_debug_write  : write-side breakpoint hits, level-valid per cycle
//   instr_commit    : pulse, current instruction retires
//   instr_flush     : pulse, current instruction is killed (wins over commit)
//   exc_ack         : exception unit accepts the debug trap
//   dr6_set_valid   : pulse, OR dr6_set into DR6
//   dr6_set         : B3..B0 to set in DR6, zero when dr6_set_valid is low
//   debug_exc_req   : debug-trap request, held until exc_ack
//   bp_pending      : accumulator contents, for observation
//   All outputs are registered.
// -----------------------------------------------------------------------------
module debug_trap_collect
  import debug_trap_collect_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dr7,
  input  logic [NUM_BP-1:0] rd_debug_read,
  input  logic [NUM_BP-1:0] wr_debug_write,
  input  logic              instr_commit,
  input  logic              instr_flush,
  input  logic              exc_ack,
  output logic              dr6_set_valid,
  output logic [NUM_BP-1:0] dr6_set,
  output logic              debug_exc_req,
  output logic [NUM_BP-1:0] bp_pending
);

  localparam int EN_W = DR7_BP_STRIDE * NUM_BP;

  logic [NUM_BP-1:0] en;
  logic              dr7_unused;

  // Only the enable pairs matter here; the rest of DR7 (lengths, types)
  // is consumed by the comparators upstream.
  assign dr7_unused = ^dr7[31:EN_W];

  debug_bp_enable_decode #(
    .NUM_BP (NUM_BP)
  ) u_en_decode (
    .dr7_lg_i (dr7[EN_W-1:0]),
    .en_o     (en)
  );

  dtc_state_e        state_q, state_d;
  logic [NUM_BP-1:0] acc_q, acc_d;
  logic              dr6_set_valid_q, dr6_set_valid_d;
  logic [NUM_BP-1:0] dr6_set_q, dr6_set_d;
  logic              req_q, req_d;

  logic [NUM_BP-1:0] hits_now;
  logic              commit_ok;

  // Hits arriving in the commit cycle belong to the committing instruction.
  assign hits_now  = acc_q | rd_debug_read | wr_debug_write;
  // A commit while a trap is still pending is a protocol error and is ignored;
  // a flush in the same cycle kills the instruction outright.
  assign commit_ok = instr_commit && !instr_flush && (state_q != DTC_REQ);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    acc_d           = hits_now;
    dr6_set_valid_d = 1'b0;
    dr6_set_d       = '0;

    if (instr_flush) begin
      acc_d = '0;
    end else if (commit_ok) begin
      acc_d           = '0;
      dr6_set_valid_d = |hits_now;
      dr6_set_d       = hits_now;
    end

    case (state_q)
      DTC_REQ: begin
        if (exc_ack) state_d = (acc_d != '0) ? DTC_ACCUM : DTC_IDLE;
      end
      default: begin
        // DR6 reports every match; only enabled matches raise the trap.
        if (commit_ok && |(hits_now & en)) state_d = DTC_REQ;
        else                               state_d = (acc_d != '0) ? DTC_ACCUM : DTC_IDLE;
      end
    endcase

    req_d = (state_d == DTC_REQ);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q         <= DTC_IDLE;
      acc_q           <= '0;
      dr6_set_valid_q <= 1'b0;
      dr6_set_q       <= '0;
      req_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      dr6_set_valid_q <= dr6_set_valid_d;
      dr6_set_q       <= dr6_set_d;
      req_q           <= req_d;
    end
  end

  assign dr6_set_valid = dr6_set_valid_q;
  assign dr6_set       = dr6_set_q;
  assign debug_exc_req = req_q;
  assign bp_pending    = acc_q;

endmodule : debug_trap_collect

// File: tb/tb_debug_trap_collect.sv
module tb_debug_trap_collect;

  logic        clk;
  logic        rst_n;
  logic [31:0] dr7;
  logic [3:0]  rd_debug_read;
  logic [3:0]  wr_debug_write;
  logic        instr_commit;
  logic        instr_flush;
  logic        exc_ack;
  logic        dr6_set_valid;
  logic [3:0]  dr6_set;
  logic        debug_exc_req;
  logic [3:0]  bp_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected DR6 pulses, in order of the commits that should produce them.
  logic [3:0] exp_q[$];

  debug_trap_collect #(.NUM_BP(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dr7            (dr7),
    .rd_debug_read  (rd_debug_read),
    .wr_debug_write (wr_debug_write),
    .instr_commit   (instr_commit),
    .instr_flush    (instr_flush),
    .exc_ack        (exc_ack),
    .dr6_set_valid  (dr6_set_valid),
    .dr6_set        (dr6_set),
    .debug_exc_req  (debug_exc_req),
    .bp_pending     (bp_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A commit while a trap is pending is a protocol error.
  always @(posedge clk) begin
    if (rst_n === 1'b1)
      assert (!(instr_commit && !instr_flush && debug_exc_req))
        else $error("commit issued while debug_exc_req pending");
  end

  // Scoreboard: every DR6 pulse must match the oldest expected entry;
  // with no pulse, dr6_set must read zero.
  always @(negedge clk) begin
    logic [3:0] e;
    n_checks++;
    if (dr6_set_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dr6_pulse: unexpected pulse dr6_set=%b, none expected at %0t", dr6_set, $time);
      end else begin
        e = exp_q.pop_front();
        if (dr6_set !== e) begin
          n_fail++;
          $display("FAIL dr6_pulse: dr6_set=%b expected %b at %0t", dr6_set, e, $time);
        end
      end
    end else if (dr6_set_valid !== 1'b0 || dr6_set !== 4'b0000) begin
      n_fail++;
      $display("FAIL dr6_idle: valid=%b dr6_set=%b expected valid=0 dr6_set=0000 at %0t",
               dr6_set_valid, dr6_set, $time);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    rd_debug_read  = 4'b0;
    wr_debug_write = 4'b0;
    instr_commit   = 1'b0;
    instr_flush    = 1'b0;
    exc_ack        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dr7   = 32'h0;
    clear_inputs();
    step(2);
    n_checks++;
    if ({dr6_set_valid, dr6_set, debug_exc_req, bp_pending} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b set=%b req=%b pending=%b expected all 0",
               dr6_set_valid, dr6_set, debug_exc_req, bp_pending);
    end
    rst_n = 1'b1;
    step(1);
    n_checks++;
    if (bp_pending !== 4'b0 || debug_exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: pending=%b req=%b expected 0000/0", bp_pending, debug_exc_req);
    end
  endtask

  task automatic test_read_trap();
    dr7 = 32'h0000_0001;
    rd_debug_read = 4'b0001;
    step(1);
    rd_debug_read = 4'b0000;
    n_checks++;
    if (bp_pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL read_hit_pending: pending=%b expected 0001", bp_pending);
    end
    step(2);
    n_checks++;
    if (bp_pending !== 4'b0001 || debug_exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL read_hold: pending=%b req=%b expected 0001/0", bp_pending, debug_exc_req);
    end
    instr_commit = 1'b1;
    exp_q.push_back(4'b0001);
    step(1);
    instr_commit = 1'b0;
    n_checks++;
    if (dr6_set_valid !== 1'b1 || dr6_set !== 4'b0001 || debug_exc_req !== 1'b1 || bp_pending !== 4'b0) begin
      n_fail++;
      $display("FAIL read_commit: valid=%b set=%b req=%b pending=%b expected 1/0001/1/0000",
               dr6_set_valid, dr6_set, debug_exc_req, bp_pending);
    end
    step(2);
    n_checks++;
    if (dr6_set_valid !== 1'b0 || debug_exc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL read_req_hold: valid=%b req=%b expected 0/1", dr6_set_valid, debug_exc_req);
    end
    exc_ack = 1'b1;
    step(1);
    exc_ack = 1'b0;
    n_checks++;
    if (debug_exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL read_ack: req=%b expected 0", debug_exc_req);
    end
    step(1);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_missing_pulse: %0d pulses outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_write_disabled();
    dr7 = 32'h0;
    wr_debug_write = 4'b0100;
    step(1);
    wr_debug_write = 4'b0000;
    instr_commit = 1'b1;
    exp_q.push_back(4'b0100);
    step(1);
    instr_commit = 1'b0;
    n_checks++;
    if (dr6_set !== 4'b0100 || debug_exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL write_disabled: set=%b req=%b expected 0100/0", dr6_set, debug_exc_req);
    end
    step(2);
    n_checks++;
    if (debug_exc_req !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL write_disabled_after: req=%b outstanding=%0d expected 0/0", debug_exc_req, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_flush();
    dr7 = 32'h0000_00FF;
    rd_debug_read = 4'b0010;
    step(1);
    rd_debug_read = 4'b0000;
    instr_flush = 1'b1;
    step(1);
    instr_flush = 1'b0;
    n_checks++;
    if (bp_pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_clear: pending=%b expected 0000", bp_pending);
    end
    step(1);
    instr_commit = 1'b1;
    step(1);
    instr_commit = 1'b0;
    n_checks++;
    if (dr6_set_valid !== 1'b0 || debug_exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_commit: valid=%b req=%b expected 0/0", dr6_set_valid, debug_exc_req);
    end
  endtask

  task automatic test_commit_flush_same();
    dr7 = 32'h0000_00C0;
    wr_debug_write = 4'b1000;
    instr_commit = 1'b1;
    instr_flush = 1'b1;
    step(1);
    clear_inputs();
    n_checks++;
    if (bp_pending !== 4'b0 || dr6_set_valid !== 1'b0 || debug_exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_flush: pending=%b valid=%b req=%b expected 0000/0/0",
               bp_pending, dr6_set_valid, debug_exc_req);
    end
    step(1);
  endtask

  task automatic test_enable_map();
    for (int n = 0; n < 4; n++) begin
      // Alternate between the L and G bit of breakpoint n.
      dr7 = 32'h1 << (2 * n + (n % 2));
      rd_debug_read = 4'b0001 << ((n + 1) % 4);
      instr_commit = 1'b1;
      exp_q.push_back(4'b0001 << ((n + 1) % 4));
      step(1);
      n_checks++;
      if (debug_exc_req !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_other_bp%0d: req=%b expected 0", n, debug_exc_req);
      end
      rd_debug_read = 4'b0001 << n;
      exp_q.push_back(4'b0001 << n);
      step(1);
      clear_inputs();
      n_checks++;
      if (debug_exc_req !== 1'b1) begin
        n_fail++;
        $display("FAIL enable_own_bp%0d: req=%b expected 1", n, debug_exc_req);
      end
      exc_ack = 1'b1;
      step(1);
      exc_ack = 1'b0;
    end
    step(1);
    n_checks++;
    if (exp_q.size() != 0 || debug_exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_map_end: outstanding=%0d req=%b expected 0/0", exp_q.size(), debug_exc_req);
      exp_q.delete();
    end
  endtask

  task automatic test_req_accum();
    dr7 = 32'h0000_0001;
    rd_debug_read = 4'b0001;
    instr_commit = 1'b1;
    exp_q.push_back(4'b0001);
    step(1);
    instr_commit = 1'b0;
    n_checks++;
    if (debug_exc_req !== 1'b1 || bp_pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL accum_first: req=%b pending=%b expected 1/0000", debug_exc_req, bp_pending);
    end
    step(1);
    rd_debug_read = 4'b0000;
    n_checks++;
    if (bp_pending !== 4'b0001 || debug_exc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL accum_in_req: pending=%b req=%b expected 0001/1", bp_pending, debug_exc_req);
    end
    exc_ack = 1'b1;
    step(1);
    exc_ack = 1'b0;
    n_checks++;
    if (debug_exc_req !== 1'b0 || bp_pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL accum_ack: req=%b pending=%b expected 0/0001", debug_exc_req, bp_pending);
    end
    instr_commit = 1'b1;
    exp_q.push_back(4'b0001);
    step(1);
    instr_commit = 1'b0;
    n_checks++;
    if (dr6_set_valid !== 1'b1 || dr6_set !== 4'b0001 || debug_exc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL accum_second: valid=%b set=%b req=%b expected 1/0001/1",
               dr6_set_valid, dr6_set, debug_exc_req);
    end
    exc_ack = 1'b1;
    step(1);
    exc_ack = 1'b0;
    step(1);
    n_checks++;
    if (exp_q.size() != 0 || bp_pending !== 4'b0) begin
      n_fail++;
      $display("FAIL accum_end: outstanding=%0d pending=%b expected 0/0000", exp_q.size(), bp_pending);
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    dr7 = 32'h0;
    rd_debug_read = 4'b0001;
    instr_commit = 1'b1;
    exp_q.push_back(4'b0001);
    step(1);
    n_checks++;
    if (dr6_set_valid !== 1'b1 || dr6_set !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b set=%b expected 1/0001", dr6_set_valid, dr6_set);
    end
    rd_debug_read = 4'b0000;
    wr_debug_write = 4'b0010;
    exp_q.push_back(4'b0010);
    step(1);
    clear_inputs();
    n_checks++;
    if (dr6_set_valid !== 1'b1 || dr6_set !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b set=%b expected 1/0010", dr6_set_valid, dr6_set);
    end
    step(1);
    n_checks++;
    if (dr6_set_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_end: valid=%b outstanding=%0d expected 0/0", dr6_set_valid, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_req();
    dr7 = 32'h0000_0003;
    rd_debug_read = 4'b0001;
    instr_commit = 1'b1;
    exp_q.push_back(4'b0001);
    step(1);
    instr_commit = 1'b0;
    rd_debug_read = 4'b0010;
    n_checks++;
    if (debug_exc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req_setup: req=%b expected 1", debug_exc_req);
    end
    step(1);
    rd_debug_read = 4'b0000;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    n_checks++;
    if ({dr6_set_valid, dr6_set, debug_exc_req, bp_pending} !== 10'b0) begin
      n_fail++;
      $display("FAIL rst_mid_req: valid=%b set=%b req=%b pending=%b expected all 0",
               dr6_set_valid, dr6_set, debug_exc_req, bp_pending);
    end
    instr_commit = 1'b1;
    step(1);
    instr_commit = 1'b0;
    n_checks++;
    if (dr6_set_valid !== 1'b0 || debug_exc_req !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_then_commit: valid=%b req=%b outstanding=%0d expected 0/0/0",
               dr6_set_valid, debug_exc_req, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_read_trap();
    test_write_disabled();
    test_flush();
    test_commit_flush_same();
    test_enable_map();
    test_req_accum();
    test_back_to_back();
    test_reset_mid_req();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_debug_trap_collect

// File: doc/debug_trap_collect.md
# debug_trap_collect

Collects data-breakpoint hits for the in-flight instruction and turns them into a DR6 update plus a debug-trap request at instruction commit. Sits directly downstream of the read-side and write-side breakpoint comparators, whose per-breakpoint `[3:0]` hit vectors it consumes. It feeds the exception unit and the DR6 register. Data breakpoints are traps: reporting is deferred until the instruction that caused them commits.

## Interface
- `NUM_BP`, default 4: number of breakpoints. Fixed at 4; the parameter exists only for width expressions.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `dr7` input 32: debug control. The enable for breakpoint n is `dr7[2n] | dr7[2n+1]` (L or G).
- `rd_debug_read` input 4: read-side hits, one bit per breakpoint, level-valid per cycle.
- `wr_debug_write` input 4: write-side hits, same format.
- `instr_commit` input 1: one-cycle pulse; the current instruction retires.
- `instr_flush` input 1: one-cycle pulse; the current instruction is killed (pipeline flush).
- `exc_ack` input 1: the exception unit accepts the debug trap.
- `dr6_set_valid` output 1: one-cycle pulse requesting the DR6 update.
- `dr6_set` output 4: B3..B0 bits to OR into DR6. Valid while `dr6_set_valid` is high, 0 otherwise.
- `debug_exc_req` output 1: debug-trap request, held until acknowledged.
- `bp_pending` output 4: accumulator contents, for observation and debug.

## Operation
- Accumulator `acc[3:0]`:
  - Each cycle, `acc <= acc | rd_debug_read | wr_debug_write`.
  - `hits_now = acc | rd_debug_read | wr_debug_write`.
- States:
  - IDLE: `acc == 0`.
  - ACCUM: `acc != 0`.
  - REQ: `debug_exc_req` is high.
- `instr_flush`:
  - Clears `acc` to 0; any hits arriving in the same cycle are dropped.
  - Moves ACCUM to IDLE.
  - Does not cancel REQ.
- `instr_commit` with `instr_flush` low:
  - `dr6_set <= hits_now`.
  - `dr6_set_valid <= (hits_now != 0)`. DR6 bits are reported for every matched breakpoint, enabled or not.
  - If `hits_now & en` is nonzero, where `en[n] = dr7[2n]|dr7[2n+1]` sampled in the commit cycle, enter REQ; otherwise go to IDLE.
  - `acc` clears to 0 in the same cycle.
- `instr_commit` and `instr_flush` together: flush wins. No DR6 update, no request, `acc` cleared.
- REQ:
  - `debug_exc_req = 1`.
  - When `exc_ack` is seen, go to IDLE on the next edge, or to ACCUM if `acc != 0`.
  - Hits keep accumulating into `acc` for the next instruction.
  - A further `instr_commit` while in REQ is a protocol error. It is ignored: no DR6 pulse and `acc` is unchanged. The bench checks for it with an assertion.
- `exc_ack` outside REQ is ignored.
- Reset values: all outputs 0, `acc = 0`, state IDLE. Reset mid-REQ drops the request with no DR6 pulse.

## Timing
- Hit in cycle N appears in `bp_pending` at N+1.
- Commit in cycle N:
  - `dr6_set_valid` and `dr6_set` are valid in cycle N+1 for exactly one cycle.
  - `debug_exc_req` rises at N+1.
- A hit and commit in the same cycle N are included in that commit's report.
- `exc_ack` in cycle M: `debug_exc_req` is low from M+1.
- Back-to-back commits in N and N+1 with no request pending produce two independent DR6 pulses at N+1 and N+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- The shared debug package holds:
  - the state encoding constants `DTC_IDLE`, `DTC_ACCUM`, `DTC_REQ`;
  - `NUM_BP`;
  - the DR7 enable-bit offsets.
- One sub-module, `debug_bp_enable_decode`, maps `dr7` to `en[3:0]`. It is shared with the instruction-breakpoint path.
- The remainder is a single flat block: accumulator, 3-state FSM, output registers.

## Test plan
- `dr7 = 32'h0000_0001`; `rd_debug_read = 4'b0001` in cycle 5; commit in cycle 8 → at cycle 9, `dr6_set_valid = 1` and `dr6_set = 4'b0001`; `debug_exc_req` is high from cycle 9 until the cycle after `exc_ack` in cycle 12, and low from cycle 13.
- `dr7 = 0`; `wr_debug_write = 4'b0100`; commit → `dr6_set = 4'b0100` pulse; `debug_exc_req` stays 0.
- `rd_debug_read = 4'b0010` in cycle 3; `instr_flush` in cycle 4; commit in cycle 6 → no DR6 pulse, no request, `bp_pending = 0` from cycle 5.
- Commit, flush and `wr_debug_write = 4'b1000` all in one cycle, with `dr7 = 32'h0000_00C0` → nothing reported; `acc` is 0 the next cycle.
- While in REQ, `rd_debug_read = 4'b0001`; `exc_ack`; next commit → second DR6 pulse with `4'b0001`, and a new request.
- `rst_n = 0` for one cycle while `debug_exc_req = 1` → all outputs 0 the next cycle; a commit afterwards reports nothing.
